// File: rtl/pmem_arbiter.sv
// Two-port physical-memory arbiter: I-cache and D-cache miss paths share one pmem port.
// Optional macro PMEM_ARB_ROUND_ROBIN_EN swaps fixed D-priority for last-grant round robin.
module pmem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        s_idle,
        s_serve_i,
        s_serve_d
    } state_e;

    state_e state_q, state_d;
    logic   d_req;
    logic   grant_i, grant_d;

    assign d_req = d_pmem_read | d_pmem_write;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
    // 0 = I-cache won last, 1 = D-cache won last
    logic last_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       last_grant <= 1'b0;
        else if (grant_d) last_grant <= 1'b1;
        else if (grant_i) last_grant <= 1'b0;
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        case (state_q)
            s_idle: begin
`ifdef PMEM_ARB_ROUND_ROBIN_EN
                if (d_req && i_pmem_read) begin
                    grant_d = ~last_grant;
                    grant_i = last_grant;
                end else begin
                    grant_d = d_req;
                    grant_i = i_pmem_read;
                end
`else
                grant_d = d_req;
                grant_i = i_pmem_read & ~d_req;
`endif
                if (grant_d)      state_d = s_serve_d;
                else if (grant_i) state_d = s_serve_i;
            end
            s_serve_i, s_serve_d: begin
                if (pmem_resp) state_d = s_idle;
            end
            default: state_d = s_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= s_idle;
        else        state_q <= state_d;
    end

    // Command is captured once at grant; requester inputs are ignored while serving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else if (grant_d) begin
            pmem_address <= d_pmem_address;
            pmem_wdata   <= d_pmem_wdata;
            pmem_write   <= d_pmem_write;
            pmem_read    <= ~d_pmem_write;
        end else if (grant_i) begin
            pmem_address <= i_pmem_address;
            pmem_write   <= 1'b0;
            pmem_read    <= 1'b1;
        end else if (state_q != s_idle && pmem_resp) begin
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
        end
    end

    assign i_pmem_resp  = (state_q == s_serve_i) & pmem_resp;
    assign d_pmem_resp  = (state_q == s_serve_d) & pmem_resp;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: expected pmem commands are queued as requests are
// driven and checked when the arbiter raises a strobe; a small memory model answers.
module tb_pmem_arbiter;
    localparam int AW = 16;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read, d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read, pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          is_d;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   tests = 0;
    int   fails = 0;
    logic tb_last;   // model of the most recent winner (1 = D)

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            tests++;
            if ((pmem_read && pmem_write) || (i_pmem_resp && d_pmem_resp)) begin
                fails++;
                $display("FAIL exclusive: rd=%b wr=%b iresp=%b dresp=%b", pmem_read, pmem_write,
                         i_pmem_resp, d_pmem_resp);
            end
        end
    end

    // Waits (bounded) for a strobe and checks it against the scoreboard head.
    task automatic wait_strobe(input int max_cyc);
        int n = 0;
        while (!(pmem_read || pmem_write) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!(pmem_read || pmem_write)) begin
            fails++;
            $display("FAIL strobe_timeout: no strobe within %0d cycles, need one", max_cyc);
        end else if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_cmd: addr=%h with empty scoreboard, need no command", pmem_address);
        end else begin
            cur = exp_q.pop_front();
            tests++;
            if (pmem_write !== cur.wr || pmem_read !== !cur.wr) begin
                fails++;
                $display("FAIL opcode: rd=%b wr=%b, need wr=%b", pmem_read, pmem_write, cur.wr);
            end
            tests++;
            if (pmem_address !== cur.addr) begin
                fails++;
                $display("FAIL address: got %h, need %h", pmem_address, cur.addr);
            end
            if (cur.wr) begin
                tests++;
                if (pmem_wdata !== cur.wdata) begin
                    fails++;
                    $display("FAIL wdata: got %h, need %h", pmem_wdata, cur.wdata);
                end
            end
        end
    endtask

    // Memory model: hold for dly cycles, then a one-cycle resp carrying data.
    task automatic respond(input int dly, input logic [LW-1:0] data);
        for (int k = 0; k < dly; k++) begin
            pmem_rdata = {4{$urandom}};
            @(negedge clk);
            tests++;
            if (pmem_address !== cur.addr || (pmem_read | pmem_write) !== 1'b1 ||
                i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
                fails++;
                $display("FAIL hold: addr=%h rd=%b wr=%b iresp=%b dresp=%b, need addr=%h strobe held no resp",
                         pmem_address, pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, cur.addr);
            end
        end
        pmem_rdata = data;
        pmem_resp  = 1'b1;
        #1;
        tests++;
        if (i_pmem_resp !== !cur.is_d || d_pmem_resp !== cur.is_d) begin
            fails++;
            $display("FAIL resp_route: iresp=%b dresp=%b, need d=%b", i_pmem_resp, d_pmem_resp, cur.is_d);
        end
        tests++;
        if (i_pmem_rdata !== data || d_pmem_rdata !== data) begin
            fails++;
            $display("FAIL rdata: i=%h d=%h, need %h", i_pmem_rdata, d_pmem_rdata, data);
        end
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        tests++;
        if (pmem_read || pmem_write || i_pmem_resp || d_pmem_resp) begin
            fails++;
            $display("FAIL post_resp: rd=%b wr=%b iresp=%b dresp=%b, need all 0",
                     pmem_read, pmem_write, i_pmem_resp, d_pmem_resp);
        end
        if (cur.is_d) begin
            d_pmem_read  = 1'b0;
            d_pmem_write = 1'b0;
        end else begin
            i_pmem_read = 1'b0;
        end
        tb_last = cur.is_d;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_pmem_read = 1'b0; i_pmem_address = '0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        #12;
        tests++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || pmem_address !== '0 || pmem_wdata !== '0 ||
            i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: rd=%b wr=%b addr=%h wdata=%h iresp=%b dresp=%b, need all 0",
                     pmem_read, pmem_write, pmem_address, pmem_wdata, i_pmem_resp, d_pmem_resp);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        tb_last = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_i_read();
        i_pmem_address = 16'h1230;
        i_pmem_read    = 1'b1;
        exp_q.push_back('{1'b0, 1'b0, 16'h1230, '0});
        wait_strobe(1);
        respond(3, {4{32'hDEADBEEF}});
    endtask

    task automatic test_d_wb_read();
        d_pmem_address = 16'h4000;
        d_pmem_wdata   = {16{8'hA5}};
        d_pmem_write   = 1'b1;
        exp_q.push_back('{1'b1, 1'b1, 16'h4000, {16{8'hA5}}});
        wait_strobe(1);
        respond(2, {4{$urandom}});
        tests++;
        if (pmem_read || pmem_write) begin
            fails++;
            $display("FAIL idle_gap: rd=%b wr=%b, need both 0", pmem_read, pmem_write);
        end
        d_pmem_address = 16'h4010;
        d_pmem_read    = 1'b1;
        exp_q.push_back('{1'b1, 1'b0, 16'h4010, '0});
        wait_strobe(1);
        respond(1, {4{$urandom}});
    endtask

    task automatic test_idle_resp();
        pmem_resp = 1'b1;
        #1;
        tests++;
        if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
            fails++;
            $display("FAIL idle_resp: iresp=%b dresp=%b, need 0 0", i_pmem_resp, d_pmem_resp);
        end
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        tests++;
        if (pmem_read || pmem_write) begin
            fails++;
            $display("FAIL idle_strobe: rd=%b wr=%b, need 0 0", pmem_read, pmem_write);
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic first_d;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
        first_d = ~tb_last;
`else
        first_d = 1'b1;
`endif
        i_pmem_address = 16'h0100;
        d_pmem_address = 16'h8000;
        i_pmem_read    = 1'b1;
        d_pmem_read    = 1'b1;
        if (first_d) begin
            exp_q.push_back('{1'b1, 1'b0, 16'h8000, '0});
            exp_q.push_back('{1'b0, 1'b0, 16'h0100, '0});
        end else begin
            exp_q.push_back('{1'b0, 1'b0, 16'h0100, '0});
            exp_q.push_back('{1'b1, 1'b0, 16'h8000, '0});
        end
        wait_strobe(1);
        respond(2, {4{$urandom}});
        wait_strobe(1);
        respond(2, {4{$urandom}});
    endtask

    task automatic test_instability();
        d_pmem_address = 16'h2000;
        d_pmem_read    = 1'b1;
        exp_q.push_back('{1'b1, 1'b0, 16'h2000, '0});
        wait_strobe(1);
        d_pmem_address = 16'h3000;
        respond(4, {4{$urandom}});
    endtask

    task automatic test_reset_midop();
        d_pmem_address = 16'h5000;
        d_pmem_read    = 1'b1;
        exp_q.push_back('{1'b1, 1'b0, 16'h5000, '0});
        wait_strobe(1);
        #2;
        rst_n     = 1'b0;
        pmem_resp = 1'b1;
        #1;
        tests++;
        if (pmem_read !== 1'b0 || pmem_address !== '0 || d_pmem_resp !== 1'b0 || i_pmem_resp !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: rd=%b addr=%h dresp=%b iresp=%b, need 0 0 0 0",
                     pmem_read, pmem_address, d_pmem_resp, i_pmem_resp);
        end
        #1;
        pmem_resp   = 1'b0;
        d_pmem_read = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        tb_last = 1'b0;
        i_pmem_address = 16'h0777;
        i_pmem_read    = 1'b1;
        exp_q.push_back('{1'b0, 1'b0, 16'h0777, '0});
        wait_strobe(1);
        respond(1, {4{$urandom}});
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d left, need 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_wb_read();
        test_idle_resp();
        test_contention();
        test_i_read();
        test_contention();
        test_instability();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single physical-memory port between the instruction cache and the data cache miss paths.
- Each cache controller issues line reads (replace) and line writes (write-back) as if it owned memory.
- The arbiter grants one requester at a time, latches that requester's command, forwards it to physical memory, and routes the response back.
- Sits between the two cache_control/datapath pairs and the pmem interface in the top-level CPU.

Parameters:
ADDR_WIDTH, 16, byte address width of line requests
LINE_WIDTH, 128, cache line width in bits

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_pmem_read  in  1  I-cache line read request, held until i_pmem_resp
i_pmem_address  in  ADDR_WIDTH  I-cache line address
i_pmem_rdata  out  LINE_WIDTH  line data to I-cache
i_pmem_resp  out  1  I-cache completion pulse
d_pmem_read  in  1  D-cache line read request, held until d_pmem_resp
d_pmem_write  in  1  D-cache write-back request, held until d_pmem_resp
d_pmem_address  in  ADDR_WIDTH  D-cache line address
d_pmem_wdata  in  LINE_WIDTH  D-cache write-back line
d_pmem_rdata  out  LINE_WIDTH  line data to D-cache
d_pmem_resp  out  1  D-cache completion pulse
pmem_read  out  1  physical memory read strobe
pmem_write  out  1  physical memory write strobe
pmem_address  out  ADDR_WIDTH  physical memory address
pmem_wdata  out  LINE_WIDTH  physical memory write line
pmem_rdata  in  LINE_WIDTH  physical memory read line
pmem_resp  in  1  physical memory completion, one cycle

Behaviour:
- States: s_idle, s_serve_i, s_serve_d. Reset enters s_idle.
- Reset values: pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, i_pmem_resp=0, d_pmem_resp=0, grant-history bit=0.
- s_idle, arbitration:
  - If D request pending (d_pmem_read|d_pmem_write), go to s_serve_d.
  - Else if i_pmem_read, go to s_serve_i.
  - Else stay in s_idle.
  - D-cache has fixed priority.
- Latching on grant: on the edge leaving s_idle, register the winner's address, write data (D only), and opcode into pmem_address, pmem_wdata, and the read/write command bit.
  - If d_pmem_read and d_pmem_write are both asserted, the write wins.
  - pmem_read/pmem_write are registered and go high the cycle after the request is first sampled (1-cycle arbitration latency).
  - They stay constant until pmem_resp.
- s_serve_x while pmem_resp=0: hold all pmem outputs stable. Requester input changes are ignored; latched values are used.
- s_serve_x with pmem_resp=1:
  - x_pmem_resp=1 combinationally in the same cycle.
  - Next state s_idle; pmem_read/pmem_write cleared on that edge.
  - pmem_rdata is forwarded combinationally to both i_pmem_rdata and d_pmem_rdata at all times. Only the granted requester sees resp.
- Mandatory s_idle cycle between transactions: pmem strobes are low for at least 1 cycle between back-to-back grants, and the completed requester has a cycle to drop its request.
- The non-granted requester waits indefinitely. Its resp stays 0 and its request is re-arbitrated in the next s_idle.
- pmem_resp in s_idle is ignored: no resp pulses.
- Reset asserted mid-transaction: immediate return to s_idle, pmem strobes low asynchronously, no resp is generated. In-flight memory operation is abandoned.
- Never: i_pmem_resp and d_pmem_resp high together; pmem_read and pmem_write high together.

Optional Feature:
- Macro PMEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit register last_grant (reset 0 = I) records the most recent winner.
  - When both caches request in s_idle, the one not equal to last_grant wins.
  - A single requester always wins.
- Undefined: fixed D-priority as above; last_grant is not implemented.

Test Plan:
- I-only read: i_pmem_read=1, addr 0x1230; pmem_resp after 3 cycles with rdata 0xDEAD...BEEF -> pmem_read high 1 cycle after request with pmem_address=0x1230; i_pmem_resp pulses once with i_pmem_rdata matching; d_pmem_resp stays 0.
- D write-back then read: d_pmem_write=1, addr 0x4000, wdata 0xA5 repeated -> pmem_write with that data. After resp, at least 1 idle cycle with strobes low, then d_pmem_read addr 0x4010 -> pmem_read with address 0x4010.
- Simultaneous requests, macro off: I addr 0x0100, D read addr 0x8000 in same cycle -> D served first; I served after the next idle cycle; exactly one resp each.
- Simultaneous requests, PMEM_ARB_ROUND_ROBIN_EN defined: after a completed D transaction, both request again -> I granted. Next contention -> D granted.
- Input instability: during s_serve_d change d_pmem_address from 0x2000 to 0x3000 -> pmem_address stays 0x2000 until pmem_resp.
- Reset mid-op: assert rst_n=0 while pmem_read=1 -> pmem_read drops without a clock edge; no resp pulse. After release with a new request, arbitration restarts from s_idle.
